// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C bus filter: bus state encoding,
// counter widths and the START/STOP qualification helper.
package i2c_pkg;

    localparam int FILT_CNT_W    = 4;
    localparam int TIMEOUT_CNT_W = 15;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_e;

    // SDA moves towards 'rising' while SCL was high before and is still high now.
    function automatic logic sda_edge_scl_high(
        input logic scl_prev,
        input logic scl_cur,
        input logic sda_prev,
        input logic sda_cur,
        input logic rising
    );
        return scl_prev & scl_cur & (sda_prev != sda_cur) & (sda_cur == rising);
    endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// One I2C line: 2-flop synchronizer followed by a saturating-match counter that
// only accepts a new level after FILT_LEN consecutive identical samples.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic line_f
);

    localparam logic [FILT_CNT_W-1:0] FILT_LEN_C = FILT_CNT_W'(FILT_LEN);

    logic                  sync1_r;
    logic                  sync2_r;
    logic [FILT_CNT_W-1:0] cnt_r;
    logic                  filt_r;

    if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
        $error("i2c_glitch_filter: FILT_LEN must be within 1..15");
    end

    // Synchronize the pin, then flip the filtered level once the mismatch has persisted long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            cnt_r   <= {FILT_CNT_W{1'b0}};
            filt_r  <= 1'b1;
        end else begin
            sync1_r <= line_in;
            sync2_r <= sync1_r;
            if (sync2_r != filt_r) begin
                if ((cnt_r + 4'd1) == FILT_LEN_C) begin
                    filt_r <= ~filt_r;
                    cnt_r  <= {FILT_CNT_W{1'b0}};
                end else begin
                    cnt_r  <= cnt_r + 4'd1;
                end
            end else begin
                cnt_r <= {FILT_CNT_W{1'b0}};
            end
        end
    end

    assign line_f = filt_r;

endmodule

// File: rtl/i2c_bus_filter.sv
// I2C bus front end: filtered SCL/SDA, SCL edge pulses, START/STOP detection
// and bus-busy tracking. Define I2C_BUS_TIMEOUT_EN to release a stuck BUSY state.
module i2c_bus_filter
    import i2c_pkg::*;
#(
    parameter int FILT_LEN    = 3,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic clk_25,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic busy,
    output logic timeout
);

    logic       scl_f_s;
    logic       sda_f_s;
    logic       scl_d_r;
    logic       sda_d_r;
    logic       scl_rise_r;
    logic       scl_fall_r;
    logic       start_r;
    logic       stop_r;
    logic       busy_r;
    logic       start_s;
    logic       stop_s;
    logic       timeout_hit_s;
    bus_state_e state_r;
    bus_state_e state_next;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 32767) begin : g_bad_timeout
        $error("i2c_bus_filter: TIMEOUT_CYC must be within 1..32767");
    end

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk     (clk_25),
        .reset   (reset),
        .line_in (scl_in),
        .line_f  (scl_f_s)
    );

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk     (clk_25),
        .reset   (reset),
        .line_in (sda_in),
        .line_f  (sda_f_s)
    );

    // A simultaneous SCL change blocks both conditions because SCL must be high in both cycles.
    assign start_s = sda_edge_scl_high(scl_d_r, scl_f_s, sda_d_r, sda_f_s, 1'b0);
    assign stop_s  = sda_edge_scl_high(scl_d_r, scl_f_s, sda_d_r, sda_f_s, 1'b1);

    // Bus ownership next-state.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next = ST_BUSY;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (stop_s || timeout_hit_s) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_BUSY;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Delayed filtered levels, registered event pulses and the bus state.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
        end else begin
            scl_d_r    <= scl_f_s;
            sda_d_r    <= sda_f_s;
            scl_rise_r <= scl_f_s & ~scl_d_r;
            scl_fall_r <= ~scl_f_s & scl_d_r;
            start_r    <= start_s;
            stop_r     <= stop_s;
            state_r    <= state_next;
            busy_r     <= (state_next == ST_BUSY);
        end
    end

`ifdef I2C_BUS_TIMEOUT_EN
    localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LIM = TIMEOUT_CNT_W'(TIMEOUT_CYC);

    logic [TIMEOUT_CNT_W-1:0] to_cnt_r;
    logic                     timeout_r;
    logic                     idle_high_s;

    assign idle_high_s   = scl_f_s & sda_f_s & (scl_f_s == scl_d_r) & (sda_f_s == sda_d_r);
    assign timeout_hit_s = (state_r == ST_BUSY) & idle_high_s
                         & ((to_cnt_r + 15'd1) == TIMEOUT_LIM);

    // Count idle-high cycles while BUSY; any line activity restarts the count.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            to_cnt_r  <= {TIMEOUT_CNT_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_hit_s;
            if ((state_r == ST_BUSY) && idle_high_s && !timeout_hit_s) begin
                to_cnt_r <= to_cnt_r + 15'd1;
            end else begin
                to_cnt_r <= {TIMEOUT_CNT_W{1'b0}};
            end
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout       = 1'b0;
`endif

    assign scl_f    = scl_f_s;
    assign sda_f    = sda_f_s;
    assign scl_rise = scl_rise_r;
    assign scl_fall = scl_fall_r;
    assign start    = start_r;
    assign stop     = stop_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_i2c_bus_filter.sv
// Scoreboard bench for i2c_bus_filter: expected pulse events are queued as the
// lines are driven and matched against every pulse the DUT emits.
module tb_i2c_bus_filter;

    typedef logic [4:0] evt_t;   // {timeout, stop, start, scl_fall, scl_rise}

    localparam evt_t EV_NONE  = 5'b00000;
    localparam evt_t EV_RISE  = 5'b00001;
    localparam evt_t EV_FALL  = 5'b00010;
    localparam evt_t EV_START = 5'b00100;
    localparam evt_t EV_STOP  = 5'b01000;
    localparam evt_t EV_TMO   = 5'b10000;
    localparam logic [7:0] RST_OUTS = 8'b1100_0000;

    logic clk_25 = 1'b0;
    logic reset;
    logic scl_in;
    logic sda_in;
    logic scl_f;
    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic busy;
    logic timeout;

    int   checks   = 0;
    int   failures = 0;
    evt_t exp_q[$];
    evt_t mon_ev;

    i2c_bus_filter #(.FILT_LEN(3), .TIMEOUT_CYC(100)) dut (
        .clk_25   (clk_25),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_f    (scl_f),
        .sda_f    (sda_f),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #20 clk_25 = ~clk_25;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_25);
    endtask

    task automatic set_line(input logic scl, input logic sda, input evt_t ev, input int settle);
        if (ev != EV_NONE) exp_q.push_back(ev);
        scl_in = scl;
        sda_in = sda;
        wait_cyc(settle);
    endtask

    // Every pulse the DUT emits must match the next queued expectation.
    always @(negedge clk_25) begin
        mon_ev = {timeout, stop, start, scl_fall, scl_rise};
        if (mon_ev != EV_NONE) begin
            if (exp_q.size() == 0) check_eq("unexpected_event", 32'(mon_ev), 32'd0);
            else                   check_eq("event", 32'(mon_ev), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        scl_in = 1'b1;
        sda_in = 1'b1;
        wait_cyc(3);
        check_eq("rst_outs", 32'({scl_f, sda_f, scl_rise, scl_fall, start, stop, busy, timeout}), 32'(RST_OUTS));
        reset = 1'b0;
        wait_cyc(4);
        check_eq("post_rst_outs", 32'({scl_f, sda_f, scl_rise, scl_fall, start, stop, busy, timeout}), 32'(RST_OUTS));

        // Short pulses must be swallowed.
        scl_in = 1'b0; wait_cyc(2); scl_in = 1'b1; wait_cyc(8);
        check_eq("glitch_scl_f", 32'(scl_f), 32'd1);
        sda_in = 1'b0; wait_cyc(1); sda_in = 1'b1; wait_cyc(8);
        check_eq("glitch_sda_f", 32'(sda_f), 32'd1);
        check_eq("glitch_busy", 32'(busy), 32'd0);

        // Pin-to-output latency: visible after edge k+4, fall pulse one cycle later.
        exp_q.push_back(EV_FALL);
        scl_in = 1'b0;
        wait_cyc(4);
        check_eq("lat_before", 32'(scl_f), 32'd1);
        wait_cyc(1);
        check_eq("lat_after", 32'(scl_f), 32'd0);
        check_eq("fall_not_yet", 32'(scl_fall), 32'd0);
        wait_cyc(1);
        check_eq("fall_pulse", 32'(scl_fall), 32'd1);
        wait_cyc(1);
        check_eq("fall_one_cycle", 32'(scl_fall), 32'd0);
        wait_cyc(4);
        set_line(1'b1, 1'b1, EV_RISE, 8);

        // START, data bit, repeated START, STOP.
        set_line(1'b1, 1'b0, EV_START, 8);
        check_eq("start_busy", 32'(busy), 32'd1);
        set_line(1'b0, 1'b0, EV_FALL, 8);
        set_line(1'b0, 1'b1, EV_NONE, 8);
        set_line(1'b1, 1'b1, EV_RISE, 8);
        set_line(1'b1, 1'b0, EV_START, 8);
        check_eq("rstart_busy", 32'(busy), 32'd1);
        set_line(1'b0, 1'b0, EV_FALL, 8);
        set_line(1'b1, 1'b0, EV_RISE, 8);
        check_eq("pre_stop_busy", 32'(busy), 32'd1);
        set_line(1'b1, 1'b1, EV_STOP, 8);
        check_eq("stop_idle", 32'(busy), 32'd0);

        // Simultaneous SCL/SDA changes yield only the SCL edge.
        set_line(1'b0, 1'b1, EV_FALL, 8);
        set_line(1'b1, 1'b0, EV_RISE, 8);
        check_eq("simul_no_start", 32'(busy), 32'd0);
        set_line(1'b0, 1'b1, EV_FALL, 8);
        check_eq("simul_no_stop", 32'(busy), 32'd0);

        // STOP while idle pulses but leaves the bus idle.
        set_line(1'b0, 1'b0, EV_NONE, 8);
        set_line(1'b1, 1'b0, EV_RISE, 8);
        set_line(1'b1, 1'b1, EV_STOP, 8);
        check_eq("stop_in_idle", 32'(busy), 32'd0);

        // START then lines idle high.
        set_line(1'b1, 1'b0, EV_START, 8);
        check_eq("tmo_start_busy", 32'(busy), 32'd1);
        set_line(1'b0, 1'b0, EV_FALL, 8);
        set_line(1'b0, 1'b1, EV_NONE, 8);
        set_line(1'b1, 1'b1, EV_RISE, 0);
`ifdef I2C_BUS_TIMEOUT_EN
        exp_q.push_back(EV_TMO);
        wait_cyc(130);
        check_eq("tmo_released", 32'(busy), 32'd0);
`else
        wait_cyc(130);
        check_eq("no_tmo_busy", 32'(busy), 32'd1);
`endif

        // Reset in the middle of a transfer.
        set_line(1'b1, 1'b0, EV_START, 8);
        check_eq("mid_busy", 32'(busy), 32'd1);
        reset  = 1'b1;
        sda_in = 1'b1;
        wait_cyc(1);
        check_eq("rst_mid_outs", 32'({scl_f, sda_f, scl_rise, scl_fall, start, stop, busy, timeout}), 32'(RST_OUTS));
        wait_cyc(1);
        reset = 1'b0;
        wait_cyc(12);
        check_eq("post_mid_rst_busy", 32'(busy), 32'd0);
        check_eq("post_mid_rst_sda", 32'(sda_f), 32'd1);

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
